// File: rtl/stall_ctrl.sv
// stall_ctrl: pipeline interlock for the five-stage MIPS core.
// Freezes PC and IF/ID and bubbles ID/EX on a register read-after-write hazard
// (Tuse/Tnew) or when ID needs HI/LO while the multi-cycle mult/div unit is busy.
// Optional build macro STALL_CTRL_PERF_EN adds the 32-bit perf counters
// perf_stall_cyc and perf_md_cyc.
module stall_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] d_rs,
    input  logic [4:0] d_rt,
    input  logic [1:0] d_tuse_rs,
    input  logic [1:0] d_tuse_rt,
    input  logic       d_md,
    input  logic [4:0] e_wreg,
    input  logic [1:0] e_tnew,
    input  logic [4:0] m_wreg,
    input  logic [1:0] m_tnew,
    input  logic       e_md_start,
    input  logic       e_md_op,
    output logic       WritePC,
    output logic       if_id_we,
    output logic       id_ex_flush,
    output logic       md_busy,
    output logic       md_err
`ifdef STALL_CTRL_PERF_EN
    ,
    output logic [31:0] perf_stall_cyc,
    output logic [31:0] perf_md_cyc
`endif
);

    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    logic [CNT_W-1:0] mdCnt_q;
    logic [CNT_W-1:0] mdCnt_d;
    logic             mdErr_q;
    logic             mdErr_d;
    logic             rsHazard;
    logic             rtHazard;
    logic             dataStall;
    logic             mdBusyRaw;
    logic             mdStall;
    logic             stallAct;
    logic [CNT_W-1:0] loadVal;

    // Read-after-write hazard per source: a producer in EX or MEM whose result
    // arrives later than ID needs it. $0 is never a real dependency, and a Tuse
    // of 3 can never be exceeded by a 2-bit Tnew.
    always_comb begin
        rsHazard = (d_rs != 5'd0) &&
                   (((e_wreg == d_rs) && (e_tnew > d_tuse_rs)) ||
                    ((m_wreg == d_rs) && (m_tnew > d_tuse_rs)));
        rtHazard = (d_rt != 5'd0) &&
                   (((e_wreg == d_rt) && (e_tnew > d_tuse_rt)) ||
                    ((m_wreg == d_rt) && (m_tnew > d_tuse_rt)));
    end

    // Combine hazards; reset forces fetch to run freely and hides the unit state.
    always_comb begin
        dataStall = rsHazard | rtHazard;
        mdBusyRaw = (mdCnt_q != '0) | e_md_start;
        mdStall   = rst & d_md & mdBusyRaw;
        stallAct  = rst & (dataStall | mdStall);
    end

    assign WritePC     = ~stallAct;
    assign if_id_we    = ~stallAct;
    assign id_ex_flush = stallAct;
    assign md_busy     = rst & mdBusyRaw;
    assign md_err      = mdErr_q;
    assign loadVal     = e_md_op ? DIV_LOAD : MULT_LOAD;

    // Busy counter: load on a start while idle or on its final busy cycle
    // (back-to-back with no gap); any earlier start is dropped and flagged.
    always_comb begin
        mdCnt_d = mdCnt_q;
        mdErr_d = mdErr_q;
        if (mdCnt_q == '0) begin
            if (e_md_start) begin
                mdCnt_d = loadVal;
            end
        end else if (mdCnt_q == CNT_ONE) begin
            mdCnt_d = e_md_start ? loadVal : '0;
        end else begin
            mdCnt_d = mdCnt_q - CNT_ONE;
            if (e_md_start) begin
                mdErr_d = 1'b1;
            end
        end
    end

    // Counter and sticky error register, cleared the moment reset asserts.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mdCnt_q <= '0;
            mdErr_q <= 1'b0;
        end else begin
            mdCnt_q <= mdCnt_d;
            mdErr_q <= mdErr_d;
        end
    end

`ifdef STALL_CTRL_PERF_EN
    logic [31:0] perfStall_q;
    logic [31:0] perfStall_d;
    logic [31:0] perfMd_q;
    logic [31:0] perfMd_d;

    // Free-running stall-cycle counters that wrap naturally at 2^32.
    always_comb begin
        perfStall_d = perfStall_q + {31'd0, stallAct};
        perfMd_d    = perfMd_q + {31'd0, mdStall};
    end

    // Perf counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perfStall_q <= 32'd0;
            perfMd_q    <= 32'd0;
        end else begin
            perfStall_q <= perfStall_d;
            perfMd_q    <= perfMd_d;
        end
    end

    assign perf_stall_cyc = perfStall_q;
    assign perf_md_cyc    = perfMd_q;
`endif

endmodule

// File: tb/tb_stall_ctrl.sv
// tb_stall_ctrl: directed and random checks of stall_ctrl against a
// time-based reference model (the unit is busy up to an absolute cycle number).
module tb_stall_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] d_rs, d_rt, e_wreg, m_wreg;
    logic [1:0] d_tuse_rs, d_tuse_rt, e_tnew, m_tnew;
    logic       d_md, e_md_start, e_md_op;
    logic       WritePC, if_id_we, id_ex_flush, md_busy, md_err;
`ifdef STALL_CTRL_PERF_EN
    logic [31:0] perf_stall_cyc, perf_md_cyc;
    logic [31:0] perfStallM = 32'd0;
    logic [31:0] perfMdM    = 32'd0;
`endif

    int checks     = 0;
    int failures   = 0;
    int cycle      = 0;
    int busyEnd    = -100;
    bit errModel   = 1'b0;
    bit expStall   = 1'b0;
    bit expMdStall = 1'b0;
    int n;

    always #5 clk = ~clk;

    stall_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .d_rs       (d_rs),
        .d_rt       (d_rt),
        .d_tuse_rs  (d_tuse_rs),
        .d_tuse_rt  (d_tuse_rt),
        .d_md       (d_md),
        .e_wreg     (e_wreg),
        .e_tnew     (e_tnew),
        .m_wreg     (m_wreg),
        .m_tnew     (m_tnew),
        .e_md_start (e_md_start),
        .e_md_op    (e_md_op),
        .WritePC    (WritePC),
        .if_id_we   (if_id_we),
        .id_ex_flush(id_ex_flush),
        .md_busy    (md_busy),
        .md_err     (md_err)
`ifdef STALL_CTRL_PERF_EN
        ,
        .perf_stall_cyc(perf_stall_cyc),
        .perf_md_cyc   (perf_md_cyc)
`endif
    );

    // A source waits if any upstream producer delivers later than it is needed.
    function automatic bit srcHazard(input int s, input int tuse, input int ew,
                                     input int et, input int mw, input int mt);
        if (s == 0) return 1'b0;
        return ((ew == s) && (et - tuse > 0)) || ((mw == s) && (mt - tuse > 0));
    endfunction

    task automatic checkBit(input string tag, input string name, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s/%s observed=%b expected=%b", tag, name, obs, exp);
        end
    endtask

    task automatic checkInt(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input bit r, input int rs, input int tuseRs, input int rt,
                                 input int tuseRt, input bit md, input int ew, input int et,
                                 input int mw, input int mt, input bit st, input bit op);
        rst        = r;
        d_rs       = 5'(rs);
        d_tuse_rs  = 2'(tuseRs);
        d_rt       = 5'(rt);
        d_tuse_rt  = 2'(tuseRt);
        d_md       = md;
        e_wreg     = 5'(ew);
        e_tnew     = 2'(et);
        m_wreg     = 5'(mw);
        m_tnew     = 2'(mt);
        e_md_start = st;
        e_md_op    = op;
        #2;
    endtask

    task automatic checkOutput(input string tag);
        bit busyM;
        if (!rst) begin
            busyEnd  = -100;
            errModel = 1'b0;
`ifdef STALL_CTRL_PERF_EN
            perfStallM = 32'd0;
            perfMdM    = 32'd0;
`endif
        end
        busyM      = rst && (e_md_start || (cycle <= busyEnd));
        expMdStall = busyM && d_md;
        expStall   = rst && (expMdStall ||
                     srcHazard(d_rs, d_tuse_rs, e_wreg, e_tnew, m_wreg, m_tnew) ||
                     srcHazard(d_rt, d_tuse_rt, e_wreg, e_tnew, m_wreg, m_tnew));
        checkBit(tag, "WritePC", WritePC, !expStall);
        checkBit(tag, "if_id_we", if_id_we, !expStall);
        checkBit(tag, "id_ex_flush", id_ex_flush, expStall);
        checkBit(tag, "md_busy", md_busy, busyM);
        checkBit(tag, "md_err", md_err, errModel);
`ifdef STALL_CTRL_PERF_EN
        checks++;
        assert (perf_stall_cyc === perfStallM) else begin
            failures++;
            $error("[TB] FAIL %s/perf_stall_cyc observed=%0d expected=%0d", tag, perf_stall_cyc, perfStallM);
        end
        checks++;
        assert (perf_md_cyc === perfMdM) else begin
            failures++;
            $error("[TB] FAIL %s/perf_md_cyc observed=%0d expected=%0d", tag, perf_md_cyc, perfMdM);
        end
`endif
    endtask

    // Advance the model across one rising edge, then return to mid-cycle.
    task automatic finishCycle();
        @(posedge clk);
        if (rst) begin
            if (e_md_start) begin
                if (cycle >= busyEnd) busyEnd = cycle + (e_md_op ? 10 : 5);
                else errModel = 1'b1;
            end
`ifdef STALL_CTRL_PERF_EN
            perfStallM = perfStallM + 32'(expStall);
            perfMdM    = perfMdM + 32'(expMdStall);
`endif
        end else begin
            busyEnd  = -100;
            errModel = 1'b0;
        end
        cycle++;
        @(negedge clk);
    endtask

    task automatic runCycle(input string tag);
        checkOutput(tag);
        finishCycle();
    endtask

    function automatic int pickReg();
        int p;
        p = $urandom_range(0, 2);
        return (p == 0) ? 0 : ((p == 1) ? 8 : 9);
    endfunction

    initial begin
        $display("[TB] stall_ctrl test start");

        // Reset forces fetch open even with every hazard present
        applyStimulus(0, 8, 1, 9, 0, 1, 8, 2, 9, 3, 1, 1); runCycle("reset0");
        applyStimulus(0, 8, 1, 9, 0, 1, 8, 2, 9, 3, 1, 0); runCycle("reset1");
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); runCycle("idle");

        // Load-use, then the same load one stage later
        applyStimulus(1, 8, 1, 0, 0, 0, 8, 2, 0, 0, 0, 0); runCycle("loadUse");
        applyStimulus(1, 8, 1, 0, 0, 0, 0, 0, 8, 1, 0, 0); runCycle("loadUseMem");

        // $0, unused operand, Tnew==Tuse boundary, rt hazard through MEM
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 2, 0, 0, 0, 0); runCycle("zeroReg");
        applyStimulus(1, 0, 0, 8, 3, 0, 8, 3, 8, 3, 0, 0); runCycle("unusedRt");
        applyStimulus(1, 8, 2, 0, 0, 0, 8, 2, 0, 0, 0, 0); runCycle("tnewEqTuse");
        applyStimulus(1, 0, 0, 9, 0, 0, 0, 0, 9, 1, 0, 0); runCycle("rtMemHazard");

        // Multiply then dependent mfhi held in ID
        n = 0;
        applyStimulus(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0); n += int'(!WritePC); runCycle("multStart");
        for (int i = 0; i < 7; i++) begin
            applyStimulus(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0); n += int'(!WritePC); runCycle("multHold");
        end
        checkInt("multStallLen", n, 6);

        // Divide
        n = 0;
        applyStimulus(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 1); n += int'(!WritePC); runCycle("divStart");
        for (int i = 0; i < 12; i++) begin
            applyStimulus(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0); n += int'(!WritePC); runCycle("divHold");
        end
        checkInt("divStallLen", n, 11);

        // Back-to-back multiplies on the final busy cycle
        n = 0;
        for (int i = 0; i < 12; i++) begin
            applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, (i == 0) || (i == 5), 0);
            n += int'(md_busy);
            runCycle("backToBack");
        end
        checkInt("backToBackBusyLen", n, 11);

        // Overlapping start while the counter holds 3
        n = 0;
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, (i == 0) || (i == 3), 0);
            n += int'(md_busy);
            runCycle("overlap");
        end
        checkInt("overlapBusyLen", n, 6);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); runCycle("errSticky");

        // Reset mid-divide with the counter at 7
        applyStimulus(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 1); runCycle("rstDivStart");
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0); runCycle("rstDivHold");
        end
        applyStimulus(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0); checkOutput("rstDivCnt7");
        rst = 1'b0;
        #1;
        checkOutput("rstMid");
        finishCycle();
        applyStimulus(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0); runCycle("rstHeld");
        applyStimulus(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0); runCycle("afterRst");

        // Random traffic with occasional resets
        for (int i = 0; i < 400; i++) begin
            applyStimulus($urandom_range(0, 49) != 0,
                          pickReg(), $urandom_range(0, 3), pickReg(), $urandom_range(0, 3),
                          $urandom_range(0, 1) == 1,
                          pickReg(), $urandom_range(0, 3), pickReg(), $urandom_range(0, 3),
                          $urandom_range(0, 5) == 0, $urandom_range(0, 1) == 1);
            runCycle("random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
